swc_rtu_rsp_queue: RTL and testbench

SWC_RTU_RSP_QUEUE -- requirements
Module: swc_rtu_rsp_queue

---
 rtl/swc_rtu_rsp_queue_pkg.sv | 20 ++
 rtl/swc_rtu_rsp_queue_fifo_mem.sv | 24 ++
 rtl/swc_rtu_rsp_queue.sv | 131 +++++++++++++
 tb/tb_swc_rtu_rsp_queue.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/swc_rtu_rsp_queue_pkg.sv
// Shared switch-core definitions: RTU response record and response-queue state encoding.
package swc_param_defs;

    localparam int unsigned c_num_ports  = 7;
    localparam int unsigned c_prio_num   = 8;
    localparam int unsigned c_prio_width = $clog2(c_prio_num);

    typedef struct packed {
        logic [c_num_ports-1:0]  mask;
        logic                    drop;
        logic [c_prio_width-1:0] prio;
    } rtu_rsp_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PRESENT,
        ST_PRESENT_LAST
    } rsp_state_e;

endpackage

// File: rtl/swc_rtu_rsp_queue_fifo_mem.sv
// Generic storage array: synchronous write, asynchronous read, no reset on contents.
module swc_rtu_rsp_fifo_mem #(
    parameter int unsigned g_depth = 8,
    parameter int unsigned g_width = 11
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(g_depth)-1:0] waddr_i,
    input  logic [g_width-1:0]         wdata_i,
    input  logic [$clog2(g_depth)-1:0] raddr_i,
    output logic [g_width-1:0]         rdata_o
);

    logic [g_width-1:0] mem_q [g_depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/swc_rtu_rsp_queue.sv
// RTU response queue: FIFO of sanitised RTU decisions with a registered head presented
// to the switch core, registered not-full backpressure and a saturating overflow counter.
module swc_rtu_rsp_queue
    import swc_param_defs::*;
#(
    parameter int unsigned g_num_ports  = c_num_ports,
    parameter int unsigned g_depth      = 8,
    parameter int unsigned g_prio_width = c_prio_width
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [g_num_ports-1:0]       in_dst_port_mask_i,
    input  logic                         in_drop_i,
    input  logic [g_prio_width-1:0]      in_prio_i,
    output logic                         rtu_rsp_valid_o,
    input  logic                         rtu_rsp_ack_i,
    output logic [g_num_ports-1:0]       rtu_dst_port_mask_o,
    output logic                         rtu_drop_o,
    output logic [g_prio_width-1:0]      rtu_prio_o,
    output logic [$clog2(g_depth):0]     count_o,
    output logic [15:0]                  ovf_cnt_o
);

    localparam int unsigned c_aw    = $clog2(g_depth);
    localparam int unsigned c_cw    = c_aw + 1;
    localparam int unsigned c_rec_w = g_num_ports + 1 + g_prio_width;

    rsp_state_e          state_q, state_d;
    logic [c_aw-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0]     count_q, count_d;
    logic                not_full_q, not_full_d;
    logic [15:0]         ovf_cnt_q, ovf_cnt_d;
    logic [c_rec_w-1:0]  head_q, head_d;

    logic                push_c, pop_c, in_drop_c;
    logic [g_num_ports-1:0] in_mask_c;
    logic [c_rec_w-1:0]  in_rec_c, mem_rdata_c;
    logic [c_aw-1:0]     next_rd_addr_c;

    // Sanitise the incoming record: an empty mask forces drop, and a drop clears the mask.
    always_comb begin
        in_drop_c      = in_drop_i | (in_dst_port_mask_i == '0);
        in_mask_c      = in_drop_c ? '0 : in_dst_port_mask_i;
        in_rec_c       = {in_mask_c, in_drop_c, in_prio_i};
        push_c         = in_valid_i & not_full_q;
        pop_c          = rtu_rsp_ack_i & (state_q != ST_EMPTY);
        next_rd_addr_c = rd_ptr_q + c_aw'(1);
    end

    swc_rtu_rsp_fifo_mem #(
        .g_depth (g_depth),
        .g_width (c_rec_w)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_rec_c),
        .raddr_i (next_rd_addr_c),
        .rdata_o (mem_rdata_c)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        head_d     = head_q;
        ovf_cnt_d  = ovf_cnt_q;

        if (push_c) wr_ptr_d = wr_ptr_q + c_aw'(1);
        if (pop_c)  rd_ptr_d = next_rd_addr_c;
        count_d    = count_q + c_cw'(push_c) - c_cw'(pop_c);
        not_full_d = (count_d != c_cw'(g_depth));

        if (in_valid_i && !not_full_q && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end

        // Head comes from the input when the queue drains into this push, else from storage.
        if (push_c && ((state_q == ST_EMPTY) || (pop_c && (count_q == c_cw'(1))))) begin
            head_d = in_rec_c;
        end else if (pop_c && (count_q > c_cw'(1))) begin
            head_d = mem_rdata_c;
        end

        case (state_q)
            ST_EMPTY: begin
                if (push_c) state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (count_d == '0)            state_d = ST_EMPTY;
                else if (count_d == c_cw'(1)) state_d = ST_PRESENT_LAST;
            end
            ST_PRESENT_LAST: begin
                if (pop_c && !push_c)      state_d = ST_EMPTY;
                else if (push_c && !pop_c) state_d = ST_PRESENT;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            not_full_q <= 1'b0;
            ovf_cnt_q  <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            not_full_q <= not_full_d;
            ovf_cnt_q  <= ovf_cnt_d;
            head_q     <= head_d;
        end
    end

    assign in_ready_o          = not_full_q;
    assign rtu_rsp_valid_o     = (state_q != ST_EMPTY);
    assign rtu_dst_port_mask_o = head_q[c_rec_w-1 -: g_num_ports];
    assign rtu_drop_o          = head_q[g_prio_width];
    assign rtu_prio_o          = head_q[g_prio_width-1:0];
    assign count_o             = count_q;
    assign ovf_cnt_o           = ovf_cnt_q;

endmodule

// File: tb/tb_swc_rtu_rsp_queue.sv
// Directed self-checking bench for swc_rtu_rsp_queue (default parameters).
module tb_swc_rtu_rsp_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [6:0]  in_dst_port_mask_i;
    logic        in_drop_i;
    logic [2:0]  in_prio_i;
    logic        rtu_rsp_valid_o;
    logic        rtu_rsp_ack_i;
    logic [6:0]  rtu_dst_port_mask_o;
    logic        rtu_drop_o;
    logic [2:0]  rtu_prio_o;
    logic [3:0]  count_o;
    logic [15:0] ovf_cnt_o;

    int checks   = 0;
    int failures = 0;

    swc_rtu_rsp_queue #(
        .g_num_ports  (7),
        .g_depth      (8),
        .g_prio_width (3)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .in_valid_i          (in_valid_i),
        .in_ready_o          (in_ready_o),
        .in_dst_port_mask_i  (in_dst_port_mask_i),
        .in_drop_i           (in_drop_i),
        .in_prio_i           (in_prio_i),
        .rtu_rsp_valid_o     (rtu_rsp_valid_o),
        .rtu_rsp_ack_i       (rtu_rsp_ack_i),
        .rtu_dst_port_mask_o (rtu_dst_port_mask_o),
        .rtu_drop_o          (rtu_drop_o),
        .rtu_prio_o          (rtu_prio_o),
        .count_o             (count_o),
        .ovf_cnt_o           (ovf_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [6:0] m, input logic d, input logic [2:0] p);
        in_valid_i         = v;
        in_dst_port_mask_i = m;
        in_drop_i          = d;
        in_prio_i          = p;
    endtask

    initial begin
        rst_i = 1'b1;
        rtu_rsp_ack_i = 1'b0;
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        tick(); tick();

        // reset values
        check_eq("rst_valid", 32'(rtu_rsp_valid_o), 32'd0);
        check_eq("rst_ready", 32'(in_ready_o), 32'd0);
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_ovf", 32'(ovf_cnt_o), 32'd0);
        check_eq("rst_mask", 32'(rtu_dst_port_mask_o), 32'd0);
        check_eq("rst_prio", 32'(rtu_prio_o), 32'd0);
        rst_i = 1'b0;
        tick();
        check_eq("ready_after_rst", 32'(in_ready_o), 32'd1);

        // single push, latency 1, ack
        drive_in(1'b1, 7'h05, 1'b0, 3'd3);
        tick();
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        check_eq("p1_valid", 32'(rtu_rsp_valid_o), 32'd1);
        check_eq("p1_mask", 32'(rtu_dst_port_mask_o), 32'h05);
        check_eq("p1_prio", 32'(rtu_prio_o), 32'd3);
        check_eq("p1_drop", 32'(rtu_drop_o), 32'd0);
        check_eq("p1_count", 32'(count_o), 32'd1);
        tick();
        check_eq("p1_hold_valid", 32'(rtu_rsp_valid_o), 32'd1);
        check_eq("p1_hold_mask", 32'(rtu_dst_port_mask_o), 32'h05);
        rtu_rsp_ack_i = 1'b1;
        tick();
        rtu_rsp_ack_i = 1'b0;
        check_eq("p1_acked_valid", 32'(rtu_rsp_valid_o), 32'd0);
        check_eq("p1_acked_count", 32'(count_o), 32'd0);

        // drop sanitising: empty mask forces drop, drop clears mask
        drive_in(1'b1, 7'h00, 1'b0, 3'd1);
        tick();
        drive_in(1'b1, 7'h12, 1'b1, 3'd2);
        tick();
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        check_eq("drop0_drop", 32'(rtu_drop_o), 32'd1);
        check_eq("drop0_mask", 32'(rtu_dst_port_mask_o), 32'h00);
        check_eq("drop0_prio", 32'(rtu_prio_o), 32'd1);
        rtu_rsp_ack_i = 1'b1;
        tick();
        check_eq("drop1_drop", 32'(rtu_drop_o), 32'd1);
        check_eq("drop1_mask", 32'(rtu_dst_port_mask_o), 32'h00);
        check_eq("drop1_prio", 32'(rtu_prio_o), 32'd2);
        tick();
        rtu_rsp_ack_i = 1'b0;
        check_eq("drop_empty", 32'(rtu_rsp_valid_o), 32'd0);

        // fill to full, overflow, drain in order
        for (int i = 0; i < 8; i++) begin
            drive_in(1'b1, 7'(i + 1), 1'b0, 3'(i));
            tick();
        end
        check_eq("full_count", 32'(count_o), 32'd8);
        check_eq("full_ready", 32'(in_ready_o), 32'd0);
        drive_in(1'b1, 7'h55, 1'b0, 3'd7);
        tick(); tick(); tick();
        check_eq("ovf_3", 32'(ovf_cnt_o), 32'd3);
        // push while full alongside a pop must still be rejected
        rtu_rsp_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_eq("drain_valid", 32'(rtu_rsp_valid_o), 32'd1);
            check_eq("drain_mask", 32'(rtu_dst_port_mask_o), 32'(i + 1));
            check_eq("drain_prio", 32'(rtu_prio_o), 32'(i));
            tick();
            drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        end
        rtu_rsp_ack_i = 1'b0;
        check_eq("drained_valid", 32'(rtu_rsp_valid_o), 32'd0);
        check_eq("drained_count", 32'(count_o), 32'd0);
        check_eq("ovf_4", 32'(ovf_cnt_o), 32'd4);

        // streaming push+pop with 3 in flight across pointer wrap
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 7'(8'h20 + i), 1'b0, 3'd0);
            tick();
        end
        rtu_rsp_ack_i = 1'b1;
        for (int j = 0; j < 20; j++) begin
            drive_in(1'b1, 7'(8'h23 + j), 1'b0, 3'd0);
            check_eq("stream_mask", 32'(rtu_dst_port_mask_o), 32'(8'h20 + j));
            check_eq("stream_count", 32'(count_o), 32'd3);
            tick();
        end
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        for (int j = 0; j < 3; j++) begin
            check_eq("stream_tail", 32'(rtu_dst_port_mask_o), 32'(8'h34 + j));
            tick();
        end
        check_eq("stream_empty", 32'(rtu_rsp_valid_o), 32'd0);

        // ack held while empty is ignored; one push -> exactly one pop
        tick(); tick();
        check_eq("ack_empty_count", 32'(count_o), 32'd0);
        drive_in(1'b1, 7'h09, 1'b0, 3'd4);
        tick();
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        check_eq("ack_push_valid", 32'(rtu_rsp_valid_o), 32'd1);
        check_eq("ack_push_mask", 32'(rtu_dst_port_mask_o), 32'h09);
        check_eq("ack_push_count", 32'(count_o), 32'd1);
        tick();
        check_eq("ack_pop_valid", 32'(rtu_rsp_valid_o), 32'd0);
        check_eq("ack_pop_count", 32'(count_o), 32'd0);
        rtu_rsp_ack_i = 1'b0;

        // mid-operation reset discards queued entries
        for (int i = 0; i < 5; i++) begin
            drive_in(1'b1, 7'(8'h40 + i), 1'b0, 3'd1);
            tick();
        end
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        check_eq("pre_rst_count", 32'(count_o), 32'd5);
        rst_i = 1'b1;
        #1;
        check_eq("rst_mid_count", 32'(count_o), 32'd0);
        check_eq("rst_mid_valid", 32'(rtu_rsp_valid_o), 32'd0);
        check_eq("rst_mid_ready", 32'(in_ready_o), 32'd0);
        tick();
        rst_i = 1'b0;
        check_eq("rst_rel_ready", 32'(in_ready_o), 32'd0);
        tick();
        check_eq("rst_post_ready", 32'(in_ready_o), 32'd1);
        check_eq("rst_post_valid", 32'(rtu_rsp_valid_o), 32'd0);
        tick();
        check_eq("rst_post_valid2", 32'(rtu_rsp_valid_o), 32'd0);
        check_eq("rst_post_ovf", 32'(ovf_cnt_o), 32'd0);
        drive_in(1'b1, 7'h44, 1'b0, 3'd6);
        tick();
        drive_in(1'b0, 7'h00, 1'b0, 3'd0);
        check_eq("post_rst_mask", 32'(rtu_dst_port_mask_o), 32'h44);
        check_eq("post_rst_prio", 32'(rtu_prio_o), 32'd6);
        check_eq("post_rst_count", 32'(count_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
